// File: rtl/morra_cinese_n.sv
// Rock-paper-scissors match controller: scores rounds, enforces the winner no-repeat rule, declares the match.
// Optional match statistics counters are enabled with `define MORRA_STATS_EN.
//
// state | meaning
// GIOCO | accepting rounds
// FINE  | one-cycle match close, final scores visible, VALID ignored
module morra_cinese_n #(
  parameter int MIN_ROUNDS = 4,
  parameter int LEAD       = 2,
  parameter int CFG_W      = 2,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             INIZIA,
  input  logic [CFG_W-1:0] CFG,
  input  logic             VALID,
  input  logic [1:0]       PRIMO,
  input  logic [1:0]       SECONDO,
  output logic [1:0]       MANCHE,
  output logic             MANCHE_VALID,
  output logic [1:0]       PARTITA,
  output logic [CNT_W-1:0] PUNTI_1,
  output logic [CNT_W-1:0] PUNTI_2,
  output logic [CNT_W-1:0] N_MANCHE,
  output logic [7:0]       VITT_1,
  output logic [7:0]       VITT_2,
  output logic [7:0]       PAREGGI
);

  typedef enum logic {GIOCO = 1'b0, FINE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       manche_q, manche_d;
  logic             mv_q, mv_d;
  logic [1:0]       partita_q, partita_d;
  logic [CNT_W-1:0] p1_q, p1_d, p2_q, p2_d, n_q, n_d, max_q, max_d;
  logic [1:0]       lmv_q, lmv_d, lwin_q, lwin_d;
  logic             win1, win2, invalid;
  logic [CNT_W:0]   diff;

  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) ||
           (a == 2'b11 && b == 2'b10);
  endfunction

  assign win1    = beats(PRIMO, SECONDO);
  assign win2    = beats(SECONDO, PRIMO);
  assign invalid = (PRIMO == 2'b00) || (SECONDO == 2'b00) ||
                   (lwin_q == 2'b01 && PRIMO == lmv_q) ||
                   (lwin_q == 2'b10 && SECONDO == lmv_q);

  always_comb begin
    state_d   = state_q;
    manche_d  = manche_q;
    mv_d      = 1'b0;
    partita_d = 2'b00;
    p1_d      = p1_q;
    p2_d      = p2_q;
    n_d       = n_q;
    max_d     = max_q;
    lmv_d     = lmv_q;
    lwin_d    = lwin_q;
    diff      = '0;
    if (INIZIA) begin
      max_d    = CNT_W'(MIN_ROUNDS) + CNT_W'(CFG);
      manche_d = 2'b00;
      p1_d     = '0;
      p2_d     = '0;
      n_d      = '0;
      lmv_d    = 2'b00;
      lwin_d   = 2'b00;
      state_d  = GIOCO;
    end else begin
      case (state_q)
        GIOCO: begin
          if (VALID) begin
            mv_d = 1'b1;
            if (invalid) begin
              manche_d = 2'b00;
            end else begin
              n_d = n_q + 1'b1;
              if (win1) begin
                manche_d = 2'b01;
                p1_d     = p1_q + 1'b1;
                lwin_d   = 2'b01;
                lmv_d    = PRIMO;
              end else if (win2) begin
                manche_d = 2'b10;
                p2_d     = p2_q + 1'b1;
                lwin_d   = 2'b10;
                lmv_d    = SECONDO;
              end else begin
                manche_d = 2'b11;
              end
              // end check uses post-update counts
              if (p1_d >= p2_d) diff = {1'b0, p1_d} - {1'b0, p2_d};
              else              diff = {1'b0, p2_d} - {1'b0, p1_d};
              if ((n_d >= CNT_W'(MIN_ROUNDS) && diff >= (CNT_W+1)'(LEAD)) ||
                  n_d == max_q) begin
                state_d = FINE;
                if (p1_d > p2_d)      partita_d = 2'b01;
                else if (p2_d > p1_d) partita_d = 2'b10;
                else                  partita_d = 2'b11;
              end
            end
          end
        end
        FINE: begin
          manche_d = 2'b00;
          p1_d     = '0;
          p2_d     = '0;
          n_d      = '0;
          lmv_d    = 2'b00;
          lwin_d   = 2'b00;
          state_d  = GIOCO;
        end
        default: state_d = GIOCO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= GIOCO;
      manche_q  <= 2'b00;
      mv_q      <= 1'b0;
      partita_q <= 2'b00;
      p1_q      <= '0;
      p2_q      <= '0;
      n_q       <= '0;
      max_q     <= CNT_W'(MIN_ROUNDS);
      lmv_q     <= 2'b00;
      lwin_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      manche_q  <= manche_d;
      mv_q      <= mv_d;
      partita_q <= partita_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      n_q       <= n_d;
      max_q     <= max_d;
      lmv_q     <= lmv_d;
      lwin_q    <= lwin_d;
    end
  end

  assign MANCHE       = manche_q;
  assign MANCHE_VALID = mv_q;
  assign PARTITA      = partita_q;
  assign PUNTI_1      = p1_q;
  assign PUNTI_2      = p2_q;
  assign N_MANCHE     = n_q;

`ifdef MORRA_STATS_EN
  logic [7:0] v1_q, v2_q, pd_q;

  // saturating counters, untouched by INIZIA
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 8'd0;
      v2_q <= 8'd0;
      pd_q <= 8'd0;
    end else begin
      if (partita_d == 2'b01 && v1_q != 8'hff) v1_q <= v1_q + 8'd1;
      if (partita_d == 2'b10 && v2_q != 8'hff) v2_q <= v2_q + 8'd1;
      if (partita_d == 2'b11 && pd_q != 8'hff) pd_q <= pd_q + 8'd1;
    end
  end

  assign VITT_1  = v1_q;
  assign VITT_2  = v2_q;
  assign PAREGGI = pd_q;
`else
  assign VITT_1  = 8'd0;
  assign VITT_2  = 8'd0;
  assign PAREGGI = 8'd0;
`endif

endmodule

// File: tb/tb_morra_cinese_n.sv
// Directed self-checking bench for morra_cinese_n; statistics expectations follow MORRA_STATS_EN.
module tb_morra_cinese_n;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       INIZIA;
  logic [1:0] CFG;
  logic       VALID;
  logic [1:0] PRIMO, SECONDO;
  logic [1:0] MANCHE, PARTITA;
  logic       MANCHE_VALID;
  logic [4:0] PUNTI_1, PUNTI_2, N_MANCHE;
  logic [7:0] VITT_1, VITT_2, PAREGGI;

  int vec = 0;
  int err = 0;
  logic [7:0] st_exp;

  morra_cinese_n dut (
    .clk(clk), .rst_n(rst_n), .INIZIA(INIZIA), .CFG(CFG), .VALID(VALID),
    .PRIMO(PRIMO), .SECONDO(SECONDO), .MANCHE(MANCHE), .MANCHE_VALID(MANCHE_VALID),
    .PARTITA(PARTITA), .PUNTI_1(PUNTI_1), .PUNTI_2(PUNTI_2), .N_MANCHE(N_MANCHE),
    .VITT_1(VITT_1), .VITT_2(VITT_2), .PAREGGI(PAREGGI)
  );

  always #5 clk = ~clk;

  task automatic play(input logic [1:0] p, input logic [1:0] s);
    PRIMO = p; SECONDO = s; VALID = 1'b1;
    @(posedge clk); #1;
    VALID = 1'b0; PRIMO = 2'b00; SECONDO = 2'b00;
  endtask

  task automatic inizia(input logic [1:0] c);
    INIZIA = 1'b1; CFG = c;
    @(posedge clk); #1;
    INIZIA = 1'b0; CFG = 2'b00;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; INIZIA = 1'b0; CFG = 2'b00; VALID = 1'b0; PRIMO = 2'b00; SECONDO = 2'b00;
    #3;
    vec++; if ({MANCHE, MANCHE_VALID, PARTITA} !== 5'b0) begin err++; $display("FAIL reset_outs got %b exp 00000", {MANCHE, MANCHE_VALID, PARTITA}); end
    vec++; if ({PUNTI_1, PUNTI_2, N_MANCHE} !== 15'b0) begin err++; $display("FAIL reset_cnt got %h exp 0", {PUNTI_1, PUNTI_2, N_MANCHE}); end
    vec++; if ({VITT_1, VITT_2, PAREGGI} !== 24'b0) begin err++; $display("FAIL reset_stats got %h exp 0", {VITT_1, VITT_2, PAREGGI}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lead;
    logic [1:0] p [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
    logic [1:0] s [4] = '{2'b11, 2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 4; i++) begin
      play(p[i], s[i]);
      vec++; if (MANCHE !== 2'b01 || MANCHE_VALID !== 1'b1) begin err++; $display("FAIL lead_manche r%0d got %b/%b exp 01/1", i+1, MANCHE, MANCHE_VALID); end
      vec++; if (PUNTI_1 !== 5'(i+1) || N_MANCHE !== 5'(i+1)) begin err++; $display("FAIL lead_cnt r%0d got p1=%0d n=%0d exp %0d", i+1, PUNTI_1, N_MANCHE, i+1); end
      vec++; if (PARTITA !== ((i == 3) ? 2'b01 : 2'b00)) begin err++; $display("FAIL lead_partita r%0d got %b exp %b", i+1, PARTITA, (i == 3) ? 2'b01 : 2'b00); end
    end
    @(posedge clk); #1;
    vec++; if (N_MANCHE !== 5'd0 || PUNTI_1 !== 5'd0 || PARTITA !== 2'b00 || MANCHE_VALID !== 1'b0)
      begin err++; $display("FAIL lead_close got n=%0d p1=%0d partita=%b mv=%b exp 0 0 00 0", N_MANCHE, PUNTI_1, PARTITA, MANCHE_VALID); end
  endtask

  task automatic test_no_repeat;
    play(2'b01, 2'b11);
    vec++; if (MANCHE !== 2'b01 || N_MANCHE !== 5'd1) begin err++; $display("FAIL norep_win got %b n=%0d exp 01 n=1", MANCHE, N_MANCHE); end
    play(2'b01, 2'b10);
    vec++; if (MANCHE !== 2'b00 || MANCHE_VALID !== 1'b1) begin err++; $display("FAIL norep_inval got %b/%b exp 00/1", MANCHE, MANCHE_VALID); end
    vec++; if (N_MANCHE !== 5'd1 || PUNTI_2 !== 5'd0) begin err++; $display("FAIL norep_cnt got n=%0d p2=%0d exp 1 0", N_MANCHE, PUNTI_2); end
    play(2'b10, 2'b00);
    vec++; if (MANCHE !== 2'b00 || MANCHE_VALID !== 1'b1 || N_MANCHE !== 5'd1 || PUNTI_1 !== 5'd1)
      begin err++; $display("FAIL none_move got %b/%b n=%0d p1=%0d exp 00/1 1 1", MANCHE, MANCHE_VALID, N_MANCHE, PUNTI_1); end
  endtask

  task automatic test_max_draw;
    logic [1:0] m [6] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
    inizia(2'd2);
    vec++; if (N_MANCHE !== 5'd0 || PUNTI_1 !== 5'd0 || MANCHE_VALID !== 1'b0 || PARTITA !== 2'b00)
      begin err++; $display("FAIL inizia_clear got n=%0d p1=%0d mv=%b partita=%b exp 0 0 0 00", N_MANCHE, PUNTI_1, MANCHE_VALID, PARTITA); end
    for (int i = 0; i < 6; i++) begin
      play(m[i], m[i]);
      vec++; if (MANCHE !== 2'b11 || N_MANCHE !== 5'(i+1)) begin err++; $display("FAIL tie r%0d got %b n=%0d exp 11 n=%0d", i+1, MANCHE, N_MANCHE, i+1); end
      vec++; if (PARTITA !== ((i == 5) ? 2'b11 : 2'b00)) begin err++; $display("FAIL tie_partita r%0d got %b exp %b", i+1, PARTITA, (i == 5) ? 2'b11 : 2'b00); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fine_valid;
    inizia(2'd0);
    play(2'b01, 2'b10);
    vec++; if (MANCHE !== 2'b10 || PUNTI_2 !== 5'd1) begin err++; $display("FAIL p2_win got %b p2=%0d exp 10 1", MANCHE, PUNTI_2); end
    play(2'b11, 2'b11);
    play(2'b01, 2'b01);
    vec++; if (PARTITA !== 2'b00 || N_MANCHE !== 5'd3) begin err++; $display("FAIL p2_mid got %b n=%0d exp 00 3", PARTITA, N_MANCHE); end
    play(2'b11, 2'b11);
    vec++; if (PARTITA !== 2'b10 || N_MANCHE !== 5'd4 || PUNTI_2 !== 5'd1) begin err++; $display("FAIL max_p2 got %b n=%0d p2=%0d exp 10 4 1", PARTITA, N_MANCHE, PUNTI_2); end
    play(2'b10, 2'b01);
    vec++; if (MANCHE_VALID !== 1'b0 || N_MANCHE !== 5'd0 || PUNTI_2 !== 5'd0 || PARTITA !== 2'b00)
      begin err++; $display("FAIL fine_valid got mv=%b n=%0d p2=%0d partita=%b exp 0 0 0 00", MANCHE_VALID, N_MANCHE, PUNTI_2, PARTITA); end
  endtask

  task automatic test_inizia_drop;
    INIZIA = 1'b1; CFG = 2'd0; VALID = 1'b1; PRIMO = 2'b01; SECONDO = 2'b11;
    @(posedge clk); #1;
    INIZIA = 1'b0; VALID = 1'b0; PRIMO = 2'b00; SECONDO = 2'b00;
    vec++; if (MANCHE_VALID !== 1'b0 || N_MANCHE !== 5'd0 || PUNTI_1 !== 5'd0)
      begin err++; $display("FAIL inizia_drop got mv=%b n=%0d p1=%0d exp 0 0 0", MANCHE_VALID, N_MANCHE, PUNTI_1); end
    play(2'b01, 2'b11);
    vec++; if (N_MANCHE !== 5'd1 || PUNTI_1 !== 5'd1) begin err++; $display("FAIL after_drop got n=%0d p1=%0d exp 1 1", N_MANCHE, PUNTI_1); end
  endtask

  task automatic test_stats;
`ifdef MORRA_STATS_EN
    st_exp = 8'd1;
`else
    st_exp = 8'd0;
`endif
    vec++; if (VITT_1 !== st_exp || VITT_2 !== st_exp || PAREGGI !== st_exp)
      begin err++; $display("FAIL stats got %0d %0d %0d exp %0d", VITT_1, VITT_2, PAREGGI, st_exp); end
    inizia(2'd0);
    vec++; if (VITT_1 !== st_exp || VITT_2 !== st_exp || PAREGGI !== st_exp)
      begin err++; $display("FAIL stats_inizia got %0d %0d %0d exp %0d", VITT_1, VITT_2, PAREGGI, st_exp); end
  endtask

  task automatic test_async_reset;
    logic [1:0] m [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
    inizia(2'd3);
    play(2'b01, 2'b11);
    play(2'b10, 2'b01);
    vec++; if (PUNTI_1 !== 5'd2) begin err++; $display("FAIL pre_rst got p1=%0d exp 2", PUNTI_1); end
    #2; rst_n = 1'b0; #1;
    vec++; if (PUNTI_1 !== 5'd0 || N_MANCHE !== 5'd0 || MANCHE !== 2'b00 || MANCHE_VALID !== 1'b0 || PARTITA !== 2'b00)
      begin err++; $display("FAIL async_rst got p1=%0d n=%0d manche=%b mv=%b partita=%b exp all 0", PUNTI_1, N_MANCHE, MANCHE, MANCHE_VALID, PARTITA); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      play(m[i], m[i]);
      vec++; if (PARTITA !== ((i == 3) ? 2'b11 : 2'b00) || N_MANCHE !== 5'(i+1))
        begin err++; $display("FAIL post_rst r%0d got %b n=%0d exp %b n=%0d", i+1, PARTITA, N_MANCHE, (i == 3) ? 2'b11 : 2'b00, i+1); end
    end
    vec++; if (VITT_1 !== 8'd0 || PAREGGI !== st_exp) begin err++; $display("FAIL stats_rst got v1=%0d par=%0d exp 0 %0d", VITT_1, PAREGGI, st_exp); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_lead();
    test_no_repeat();
    test_max_draw();
    test_fine_valid();
    test_inizia_drop();
    test_stats();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
